cap_sense_scanner: RTL and testbench
====================================

CAP_SENSE_SCANNER -- requirements
Module: cap_sense_scanner

Interface
REQ-001 Parameter N_SENSORS, 9, number of capacitive pads scanned in parallel.
REQ-002 Parameter CNT_W, 12, width of charge-time counter and threshold.
REQ-003 Parameter DISCHARGE_CYCLES, 64, cycles the drive line is held low before each charge phase.
REQ-004 Parameter TIMEOUT, 4095, maximum charge-phase length in cycles; must be at most 2^CNT_W-1.
REQ-005 Parameter DEBOUNCE, 3, consecutive agreeing scans required to change a debounced pad state.
REQ-006 Port clock  in  1  single system clock; all state is rising-edge.
REQ-007 Port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 Port enable  in  1  1 = run continuous scans; 0 = stop at the end of the current scan.
REQ-009 Port threshold  in  CNT_W  charge count strictly above which a pad reads as touched; sampled at the start of EVALUATE.
REQ-010 Port capacitive_sensors_in  in  N_SENSORS  asynchronous pad sense inputs.
REQ-011 Port clear_hits  in  N_SENSORS  per-pad single-cycle pulse that clears the sticky hit flag.
REQ-012 Port capacitive_sensors_out  out  1  shared charge-drive line for all pads.
REQ-013 Port touched  out  N_SENSORS  debounced pad state.
REQ-014 Port hit_latched  out  N_SENSORS  sticky flag per pad, set on a debounced touch rising edge.
REQ-015 Port scan_done  out  1  one-cycle pulse at the end of every EVALUATE.
REQ-016 Port busy  out  1  1 whenever the FSM is not IDLE.

Function
REQ-017 capacitive_sensors_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-018 FSM states SHALL be IDLE, DISCHARGE, CHARGE and EVALUATE.
REQ-019 IDLE SHALL go to DISCHARGE when enable=1.
REQ-020 DISCHARGE SHALL drive capacitive_sensors_out=0 for exactly DISCHARGE_CYCLES cycles, then go to CHARGE with the counter at 0.
REQ-021 CHARGE SHALL drive capacitive_sensors_out=1 and increment the counter by 1 each cycle.
REQ-022 CHARGE: for each unresolved pad, on the first cycle its synchronized input is 1, the module SHALL store the current counter value as that pad's count and mark the pad resolved.
REQ-023 CHARGE SHALL exit to EVALUATE on the cycle all pads are resolved, or when the counter equals TIMEOUT.
REQ-024 On a TIMEOUT exit, every unresolved pad SHALL receive count=TIMEOUT.
REQ-025 A pad that is already 1 in the first CHARGE cycle SHALL record count 0.
REQ-026 EVALUATE SHALL last 1 cycle: raw[i] = (count[i] > threshold), unsigned compare.
REQ-027 EVALUATE SHALL update the per-pad debounce counters, pulse scan_done, then go to DISCHARGE if enable=1, else IDLE.
REQ-028 Debounce: when raw[i] differs from touched[i], a per-pad counter SHALL increment, and touched[i] SHALL flip when it reaches DEBOUNCE.
REQ-029 Debounce: when raw[i] equals touched[i], that counter SHALL reset to 0.
REQ-030 hit_latched[i] SHALL set in the cycle touched[i] goes 0->1 and clear on clear_hits[i]=1; if both occur in the same cycle, set SHALL win.
REQ-031 Deasserting enable mid-scan SHALL NOT abort the scan; the scan completes and the FSM then returns to IDLE.
REQ-032 capacitive_sensors_out SHALL be 0 in IDLE, DISCHARGE and EVALUATE.

Reset
REQ-033 With reset=0, the FSM SHALL go to IDLE immediately (asynchronously).
REQ-034 Reset SHALL force capacitive_sensors_out=0, touched=0, hit_latched=0, scan_done=0, busy=0, and clear all counts, debounce counters and synchronizer flops.
REQ-035 Reset asserted mid-scan SHALL discard all partial counts.

Structure
REQ-036 The FSM state encoding and default parameter constants SHALL live in a shared package, cap_sense_pkg.
REQ-037 One sub-module, cap_sense_debounce (one instance per pad, generate loop), SHALL hold the debounce counter, touched bit and hit_latched bit.

Verification
REQ-038 Pad 4 input rises 100 cycles into CHARGE, others at 20, threshold=50 -> after 3 scans touched=9'h010 and hit_latched=9'h010.
REQ-039 All pads held 0 -> CHARGE lasts exactly 4096 cycles, all counts=4095; with threshold=4095 touched stays 0, with threshold=4094 touched=9'h1FF after 3 scans.
REQ-040 Pad 0 exceeds the threshold on scans 1 and 2, is below on scan 3, then exceeds on scans 4, 5 and 6 -> touched[0] does not rise until after scan 6.
REQ-041 clear_hits[4] pulsed in the same cycle touched[4] rises -> hit_latched[4]=1; a clear pulse one cycle later -> hit_latched[4]=0.
REQ-042 enable dropped during CHARGE -> scan completes, scan_done pulses once, then busy=0 and capacitive_sensors_out=0.
REQ-043 reset=0 asserted mid-CHARGE -> outputs clear in the same cycle; after release, the first scan_done occurs no earlier than 64 DISCHARGE cycles plus the CHARGE cycles plus 1.

Source files
------------

// File: rtl/cap_sense_pkg.sv
// Shared definitions for the capacitive-sense scanner: FSM encoding and default
// parameter values used by the scanner top and its per-pad debounce cells.
package cap_sense_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISCHARGE,
      ST_CHARGE,
      ST_EVALUATE
   } scan_state_t;

   localparam int DEF_N_SENSORS        = 9;
   localparam int DEF_CNT_W            = 12;
   localparam int DEF_DISCHARGE_CYCLES = 64;
   // Must stay at or below 2**CNT_W-1 so the charge counter can reach it.
   localparam int DEF_TIMEOUT          = 4095;
   localparam int DEF_DEBOUNCE         = 3;

endpackage

// File: rtl/cap_sense_debounce.sv
// Per-pad debounce cell: counts consecutive disagreeing scans, flips the
// debounced state after DEBOUNCE of them, and keeps a sticky touch-hit flag.
module cap_sense_debounce
   import cap_sense_pkg::*;
#(
   parameter int DEBOUNCE = DEF_DEBOUNCE
) (
   input  logic clock,
   input  logic reset,
   input  logic update,
   input  logic raw,
   input  logic clear_hit,
   output logic touched,
   output logic hit_latched
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);

   logic [DB_W-1:0] disagree_cnt;
   logic            differs;
   logic            flip;
   logic            rise;

   assign differs = update && (raw != touched);
   assign flip    = differs && (disagree_cnt == DB_W'(DEBOUNCE - 1));
   assign rise    = flip && !touched;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         disagree_cnt <= '0;
         touched      <= 1'b0;
         hit_latched  <= 1'b0;
      end else begin
         if (update) begin
            if (!differs) begin
               disagree_cnt <= '0;
            end else if (flip) begin
               disagree_cnt <= '0;
               touched      <= ~touched;
            end else begin
               disagree_cnt <= disagree_cnt + 1'b1;
            end
         end
         // A new touch outranks a simultaneous clear request.
         if (rise) begin
            hit_latched <= 1'b1;
         end else if (clear_hit) begin
            hit_latched <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cap_sense_scanner.sv
// Capacitive pad scanner: discharges all pads, times how long each takes to
// charge through the shared drive line, then debounces a thresholded result.
module cap_sense_scanner
   import cap_sense_pkg::*;
#(
   parameter int N_SENSORS        = DEF_N_SENSORS,
   parameter int CNT_W            = DEF_CNT_W,
   parameter int DISCHARGE_CYCLES = DEF_DISCHARGE_CYCLES,
   parameter int TIMEOUT          = DEF_TIMEOUT,
   parameter int DEBOUNCE         = DEF_DEBOUNCE
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [CNT_W-1:0]     threshold,
   input  logic [N_SENSORS-1:0] capacitive_sensors_in,
   input  logic [N_SENSORS-1:0] clear_hits,
   output logic                 capacitive_sensors_out,
   output logic [N_SENSORS-1:0] touched,
   output logic [N_SENSORS-1:0] hit_latched,
   output logic                 scan_done,
   output logic                 busy
);

   localparam int DIS_W = $clog2(DISCHARGE_CYCLES + 1);

   scan_state_t          state;
   scan_state_t          state_next;
   logic [N_SENSORS-1:0] sync_q1;
   logic [N_SENSORS-1:0] sync_q2;
   logic [DIS_W-1:0]     dis_cnt;
   logic [CNT_W-1:0]     charge_cnt;
   logic [N_SENSORS-1:0] resolved;
   logic [CNT_W-1:0]     pad_count [N_SENSORS];
   logic                 dis_last;
   logic                 charge_timeout;
   logic                 all_resolved;
   logic                 evaluate;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values; blocking here would collapse the two stages.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= capacitive_sensors_in;
         sync_q2 <= sync_q1;
      end
   end

   assign dis_last       = dis_cnt == DIS_W'(DISCHARGE_CYCLES - 1);
   assign charge_timeout = charge_cnt == CNT_W'(TIMEOUT);
   // Pads crossing this cycle count as resolved so CHARGE ends on that cycle.
   assign all_resolved   = &(resolved | sync_q2);
   assign evaluate       = state == ST_EVALUATE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_next unassigned, which would otherwise infer a latch.
      state_next = state;
      case (state)
         ST_IDLE:      if (enable) state_next = ST_DISCHARGE;
         ST_DISCHARGE: if (dis_last) state_next = ST_CHARGE;
         ST_CHARGE:    if (all_resolved || charge_timeout) state_next = ST_EVALUATE;
         ST_EVALUATE:  state_next = enable ? ST_DISCHARGE : ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      capacitive_sensors_out = 1'b0;
      scan_done              = 1'b0;
      busy                   = 1'b1;
      case (state)
         ST_IDLE:     busy = 1'b0;
         ST_CHARGE:   capacitive_sensors_out = 1'b1;
         ST_EVALUATE: scan_done = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dis_cnt    <= '0;
         charge_cnt <= '0;
         resolved   <= '0;
         // NOTE: the count array is a handful of flops, not RAM, and a reset
         // mid-scan must drop partial counts, so it is reset explicitly.
         for (int i = 0; i < N_SENSORS; i++) begin
            pad_count[i] <= '0;
         end
      end else begin
         case (state)
            ST_DISCHARGE: begin
               dis_cnt    <= dis_last ? '0 : dis_cnt + 1'b1;
               charge_cnt <= '0;
               resolved   <= '0;
            end
            ST_CHARGE: begin
               charge_cnt <= charge_cnt + 1'b1;
               for (int i = 0; i < N_SENSORS; i++) begin
                  if (!resolved[i]) begin
                     if (sync_q2[i]) begin
                        pad_count[i] <= charge_cnt;
                        resolved[i]  <= 1'b1;
                     end else if (charge_timeout) begin
                        pad_count[i] <= CNT_W'(TIMEOUT);
                     end
                  end
               end
            end
            default: dis_cnt <= '0;
         endcase
      end
   end

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_pad
      cap_sense_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_debounce (
         .clock       (clock),
         .reset       (reset),
         .update      (evaluate),
         .raw         (pad_count[g] > threshold),
         .clear_hit   (clear_hits[g]),
         .touched     (touched[g]),
         .hit_latched (hit_latched[g])
      );
   end

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Self-checking bench for cap_sense_scanner: pads are modelled as RC delays on
// the drive line and results are compared against a scan-level reference model.
module tb_cap_sense_scanner;

   localparam int N     = 9;
   localparam int CW    = 12;
   localparam int TOUT  = 4095;
   localparam int DIS   = 64;
   localparam int DB    = 3;
   localparam int NEVER = 100000;
   localparam int STUCK = -1;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [CW-1:0] threshold;
   logic [N-1:0]  capacitive_sensors_in;
   logic [N-1:0]  clear_hits;
   logic          capacitive_sensors_out;
   logic [N-1:0]  touched;
   logic [N-1:0]  hit_latched;
   logic          scan_done;
   logic          busy;

   always #5 clock = ~clock;

   cap_sense_scanner dut (
      .clock                  (clock),
      .reset                  (reset),
      .enable                 (enable),
      .threshold              (threshold),
      .capacitive_sensors_in  (capacitive_sensors_in),
      .clear_hits             (clear_hits),
      .capacitive_sensors_out (capacitive_sensors_out),
      .touched                (touched),
      .hit_latched            (hit_latched),
      .scan_done              (scan_done),
      .busy                   (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Pad behaviour: cycles after the drive line rises before the pad input
   // goes high; STUCK = shorted high, NEVER = open pad.
   int pad_delay [N];
   int m_count   [N];
   int m_db      [N];
   logic [N-1:0] m_touched;
   logic [N-1:0] m_hit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_touched = '0;
      m_hit     = '0;
      for (int i = 0; i < N; i++) m_db[i] = 0;
   endtask

   function automatic logic [N-1:0] stuck_mask();
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = (pad_delay[i] == STUCK);
      return m;
   endfunction

   // Runs one scan, checks charge length, scan_done and the debounced result.
   // Returns at the negedge of the cycle after EVALUATE.
   task automatic run_scan(input logic [N-1:0] clr_eval, input int drop_en_at,
                           output int wait_cyc, output int len);
      int c;
      int mx;
      logic [N-1:0] raw;
      logic [N-1:0] rises;
      wait_cyc = 0;
      len      = 0;
      capacitive_sensors_in = stuck_mask();
      while (capacitive_sensors_out !== 1'b1 && wait_cyc < 200) begin
         @(negedge clock);
         wait_cyc++;
      end
      if (capacitive_sensors_out !== 1'b1) begin
         check("charge_start", capacitive_sensors_out, 1);
         return;
      end
      c = 0;
      while (capacitive_sensors_out === 1'b1 && c < TOUT + 10) begin
         for (int i = 0; i < N; i++)
            capacitive_sensors_in[i] = (pad_delay[i] == STUCK) || (c >= pad_delay[i]);
         if (c == drop_en_at) enable = 1'b0;
         c++;
         @(negedge clock);
      end
      len = c;
      // Two synchronizer stages delay each pad's edge by two cycles.
      mx = 0;
      for (int i = 0; i < N; i++) begin
         if (pad_delay[i] == STUCK) m_count[i] = 0;
         else m_count[i] = (pad_delay[i] + 2 > TOUT) ? TOUT : pad_delay[i] + 2;
         if (m_count[i] > mx) mx = m_count[i];
      end
      check("charge_len", len, mx + 1);
      check("scan_done_eval", scan_done, 1);
      check("busy_eval", busy, 1);
      clear_hits = clr_eval;
      rises = '0;
      for (int i = 0; i < N; i++) begin
         raw[i] = m_count[i] > int'(threshold);
         if (raw[i] != m_touched[i]) begin
            m_db[i]++;
            if (m_db[i] == DB) begin
               m_touched[i] = raw[i];
               m_db[i]      = 0;
               rises[i]     = raw[i];
            end
         end else begin
            m_db[i] = 0;
         end
      end
      m_hit = (m_hit & ~clr_eval) | rises;
      capacitive_sensors_in = stuck_mask();
      @(negedge clock);
      clear_hits = '0;
      check("scan_done_pulse", scan_done, 0);
      check("touched", touched, m_touched);
      check("hit_latched", hit_latched, m_hit);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_drive"}, capacitive_sensors_out, 0);
      check({tag, "_touched"}, touched, 0);
      check({tag, "_hit"}, hit_latched, 0);
      check({tag, "_done"}, scan_done, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_reset_outputs("reset");
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int len;
      int dones;
      int busys;
      logic [N-1:0] mask;

      reset                 = 1'b1;
      enable                = 1'b0;
      threshold             = 12'd50;
      capacitive_sensors_in = '0;
      clear_hits            = '0;
      #2;
      do_reset();

      // Pad 4 slow (large capacitance), others fast; clear collides with the rise.
      for (int i = 0; i < N; i++) pad_delay[i] = 20;
      pad_delay[4] = 100;
      enable = 1'b1;
      run_scan('0, -1, w, len);
      check("first_scan_wait", w, 1 + DIS);
      run_scan('0, -1, w, len);
      check("pad4_two_scans", touched, 9'h000);
      run_scan(9'h010, -1, w, len);
      check("pad4_touched", touched, 9'h010);
      check("pad4_hit_set_wins", hit_latched, 9'h010);
      clear_hits = 9'h010;
      @(negedge clock);
      clear_hits = '0;
      m_hit[4] = 1'b0;
      check("pad4_hit_cleared", hit_latched, m_hit);
      check("pad4_hit_zero", hit_latched[4], 0);

      // Pad 0 glitches below threshold on scan 3; debounce restarts.
      do_reset();
      for (int i = 0; i < N; i++) pad_delay[i] = 18;
      for (int s = 1; s <= 6; s++) begin
         pad_delay[0] = (s == 3) ? 0 : 98;
         run_scan('0, -1, w, len);
         if (s == 5) check("pad0_not_yet", touched[0], 0);
      end
      check("pad0_after_6", touched[0], 1);

      // Enable dropped mid-CHARGE: the scan finishes, then the FSM idles.
      run_scan('0, 10, w, len);
      check("drop_busy", busy, 0);
      check("drop_drive", capacitive_sensors_out, 0);
      dones = 0;
      busys = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clock);
         if (scan_done === 1'b1) dones++;
         if (busy !== 1'b0) busys++;
      end
      check("drop_no_more_done", dones, 0);
      check("drop_stays_idle", busys, 0);
      enable = 1'b1;

      // Random pads, thresholds and clear pulses.
      for (int s = 0; s < 12; s++) begin
         threshold = CW'($urandom_range(0, 200));
         for (int i = 0; i < N; i++)
            pad_delay[i] = ($urandom_range(0, 9) == 0) ? STUCK : int'($urandom_range(0, 180));
         run_scan(N'($urandom_range(0, 511)), -1, w, len);
         mask = N'($urandom_range(0, 511));
         clear_hits = mask;
         @(negedge clock);
         clear_hits = '0;
         m_hit = m_hit & ~mask;
         check("rand_clear", hit_latched, m_hit);
      end

      // Open pads: every scan times out at the full count.
      for (int i = 0; i < N; i++) pad_delay[i] = NEVER;
      threshold = 12'd4095;
      for (int s = 0; s < 3; s++) begin
         run_scan('0, -1, w, len);
         if (s == 0) check("timeout_len", len, 4096);
      end
      check("timeout_th4095", touched, 9'h000);
      threshold = 12'd4094;
      for (int s = 0; s < 3; s++) run_scan('0, -1, w, len);
      check("timeout_th4094", touched, 9'h1FF);

      // Reset mid-CHARGE, then time the first scan after release.
      for (int i = 0; i < N; i++) pad_delay[i] = 300;
      threshold = 12'd50;
      capacitive_sensors_in = '0;
      w = 0;
      while (capacitive_sensors_out !== 1'b1 && w < 200) begin
         @(negedge clock);
         w++;
      end
      repeat (50) @(negedge clock);
      check("mid_charge", capacitive_sensors_out, 1);
      do_reset();
      run_scan('0, -1, w, len);
      check("rst_first_done", w + len, DIS + 303 + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
